// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the PC fetch unit.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StHold,
    StErr
  } fetch_state_e;

  typedef enum logic [1:0] {
    RdSeq,
    RdBr,
    RdJ,
    RdJr
  } redir_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC target selection with redirect priority and alignment check.
module next_pc_sel
  import mips_pc_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        jump,
  input  logic [27:0] jump_addr,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output logic        live_redir,
  output logic [31:0] live_target,
  output logic [31:0] target,
  output logic        misaligned
);

  redir_e live_kind;

  always_comb begin
    live_kind = RdSeq;
    if (jump_reg) begin
      live_kind = RdJr;
    end else if (jump) begin
      live_kind = RdJ;
    end else if (branch_taken) begin
      live_kind = RdBr;
    end
  end

  always_comb begin
    live_target = pc_plus4;
    unique case (live_kind)
      RdJr:    live_target = jr_addr;
      RdJ:     live_target = {pc_plus4[31:28], jump_addr};
      RdBr:    live_target = pc_plus4 + (branch_addr << 2);
      default: live_target = pc_plus4;
    endcase
  end

  assign live_redir = (live_kind != RdSeq);

  // A redirect in the advance cycle itself beats anything already pending.
  assign target     = live_redir ? live_target : (pend_valid ? pend_target : pc_plus4);
  assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS-style PC register and instruction fetch FSM with pending redirect and fetch timeout.
module pc_fetch_unit
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [7:0]  IMEM_TIMEOUT = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        jump,
  input  logic [27:0] jump_addr,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        addr_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic [7:0]   to_cnt_q, to_cnt_d;
  logic         addr_err_q, addr_err_d;

  logic         advance;
  logic         live_redir;
  logic [31:0]  live_target;
  logic [31:0]  target;
  logic         misaligned;

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + PC_INC;
  assign addr_err  = addr_err_q;

  next_pc_sel u_next_pc_sel (
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .jump_reg     (jump_reg),
    .jr_addr      (jr_addr),
    .pend_valid   (pend_valid_q),
    .pend_target  (pend_target_q),
    .live_redir   (live_redir),
    .live_target  (live_target),
    .target       (target),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    to_cnt_d      = to_cnt_q;
    addr_err_d    = addr_err_q;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    advance       = 1'b0;

    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_valid = 1'b1;
          to_cnt_d    = 8'd0;
          if (stall) begin
            state_d = StHold;
          end else begin
            advance = 1'b1;
          end
        end else if (IMEM_TIMEOUT != 8'd0) begin
          if (to_cnt_q + 8'd1 == IMEM_TIMEOUT) begin
            addr_err_d = 1'b1;
            state_d    = StErr;
            to_cnt_d   = 8'd0;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          advance = 1'b1;
          state_d = StFetch;
        end
      end
      default: ;
    endcase

    if (advance) begin
      if (misaligned) begin
        addr_err_d = 1'b1;
        state_d    = StErr;
      end else begin
        pc_d = target;
      end
      pend_valid_d = 1'b0;
    end else if (live_redir && state_q != StErr) begin
      pend_valid_d  = 1'b1;
      pend_target_d = live_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      to_cnt_q      <= 8'd0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      to_cnt_q      <= to_cnt_d;
      addr_err_q    <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        jump;
  logic [27:0] jump_addr;
  logic        jump_reg;
  logic [31:0] jr_addr;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .IMEM_TIMEOUT (8'd4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .jump_reg     (jump_reg),
    .jr_addr      (jr_addr),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jr_to(input logic [31:0] a);
    jump_reg = 1'b1;
    jr_addr  = a;
    imem_ack = 1'b1;
    tick();
    jump_reg = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    jump = 1'b0; jump_addr = 28'h0; jump_reg = 1'b0; jr_addr = 32'h0;
    imem_ack = 1'b1;
    tick(); tick();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc_plus4", pc_plus4, 32'h4);
    check_eq("rst_req", {31'h0, imem_req}, 32'h0);
    check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("rst_err", {31'h0, addr_err}, 32'h0);

    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("seq_addr%0d", i), imem_addr, 32'(i * 4));
      check_eq($sformatf("seq_valid%0d", i), {31'h0, instr_valid}, 32'h1);
      tick();
    end
    check_eq("seq_after", pc, 32'h10);

    jr_to(32'h100);
    check_eq("jr_100", pc, 32'h100);
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    check_eq("br_back", pc, 32'hFC);

    jr_to(32'h100);
    branch_taken = 1'b1; branch_addr = 32'h10;
    tick();
    branch_taken = 1'b0;
    check_eq("br_fwd", pc, 32'h144);

    jr_to(32'h9000_0010);
    jump = 1'b1; jump_addr = 28'h000_0040; branch_taken = 1'b1; branch_addr = 32'h10;
    tick();
    jump = 1'b0; branch_taken = 1'b0;
    check_eq("jump_wins", pc, 32'h9000_0040);

    jr_to(32'hFFFF_FFFC);
    check_eq("wrap_plus4", pc_plus4, 32'h0);
    tick();
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_err", {31'h0, addr_err}, 32'h0);

    // Stall with ack: instr_valid still pulses, redirect goes pending.
    stall = 1'b1; jump_reg = 1'b1; jr_addr = 32'h2000; imem_ack = 1'b1;
    #1;
    check_eq("stall_valid", {31'h0, instr_valid}, 32'h1);
    tick();
    jump_reg = 1'b0; imem_ack = 1'b0;
    check_eq("hold_pc", pc, 32'h0);
    check_eq("hold_req", {31'h0, imem_req}, 32'h0);
    tick();
    stall = 1'b0;
    tick();
    check_eq("pend_pc", pc, 32'h2000);
    check_eq("pend_req", {31'h0, imem_req}, 32'h1);
    imem_ack = 1'b1;
    tick();
    check_eq("pend_cleared", pc, 32'h2004);

    imem_ack = 1'b0;
    tick(); tick();
    check_eq("addr_stable", imem_addr, 32'h2004);
    check_eq("no_early_to", {31'h0, addr_err}, 32'h0);
    imem_ack = 1'b1;
    tick();
    check_eq("after_wait", pc, 32'h2008);

    jr_to(32'h2002);
    check_eq("mis_err", {31'h0, addr_err}, 32'h1);
    check_eq("mis_req", {31'h0, imem_req}, 32'h0);
    check_eq("mis_pc", pc, 32'h2008);
    tick();
    check_eq("err_frozen", pc, 32'h2008);

    rst_n = 1'b0;
    #1;
    check_eq("rst2_pc", pc, 32'h0);
    check_eq("rst2_err", {31'h0, addr_err}, 32'h0);
    tick();
    rst_n = 1'b1; imem_ack = 1'b0;
    tick();
    tick(); tick(); tick();
    check_eq("to_pre", {31'h0, addr_err}, 32'h0);
    tick();
    check_eq("to_err", {31'h0, addr_err}, 32'h1);
    check_eq("to_req", {31'h0, imem_req}, 32'h0);

    rst_n = 1'b0;
    #1;
    check_eq("rst3_pc", pc, 32'h0);
    check_eq("rst3_err", {31'h0, addr_err}, 32'h0);
    check_eq("rst3_req", {31'h0, imem_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter IMEM_TIMEOUT, default 8'd0, is the max imem_ack wait in cycles; 0 disables the timeout.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-005 Port stall, input, 1, holds the PC and suppresses new fetch requests.
REQ-006 Port branch_taken, input, 1, is the conditional-branch redirect.
REQ-007 Port branch_addr, input, 32, is the sign-extended 16-bit word offset (not yet shifted).
REQ-008 Port jump, input, 1, is the J/JAL redirect.
REQ-009 Port jump_addr, input, 28, is the 26-bit jump field already shifted left by 2.
REQ-010 Port jump_reg, input, 1, is the JR/JALR redirect.
REQ-011 Port jr_addr, input, 32, is the register-sourced target.
REQ-012 Port imem_ack, input, 1, is the instruction-memory acknowledge for the current request.
REQ-013 Port imem_req, output, 1, is the fetch request.
REQ-014 Port imem_addr, output, 32, is the fetch address and equals pc.
REQ-015 Port pc, output, 32, is the current program counter.
REQ-016 Port pc_plus4, output, 32, is pc+4 modulo 2^32, for link registers.
REQ-017 Port instr_valid, output, 1, is a one-cycle pulse for the cycle imem_ack is accepted.
REQ-018 Port addr_err, output, 1, is a sticky flag for a misaligned target or a fetch timeout.

Function
REQ-019 Target priority: jump_reg > jump > branch_taken > sequential.
REQ-020 Targets:
- sequential: pc_plus4
- branch: pc_plus4 + (branch_addr << 2), 32-bit wrap
- jump: {pc_plus4[31:28], jump_addr}
- jump_reg: jr_addr
REQ-021 FSM states and transitions:
- S_BOOT: reset state; goes to S_FETCH on the first clock after rst_n deasserts; imem_req=0.
- S_FETCH: imem_req=1. On imem_ack, advances if stall=0, otherwise goes to S_HOLD.
- S_HOLD: imem_req=0. Advances and returns to S_FETCH on the first cycle with stall=0.
- S_ERR: imem_req=0 and pc frozen until reset.
REQ-022 Advance cycle: pc loads the selected target; the next request issues in the following cycle.
REQ-023 Redirect latching: a redirect asserted in a non-advance cycle is captured with its target into a one-entry pending register.
REQ-024 At the next advance, a pending redirect takes precedence over the sequential path; a redirect arriving in the advance cycle itself overrides the pending one.
REQ-025 A later redirect overwrites the pending entry, subject to REQ-019 priority between simultaneous redirects.
REQ-026 The pending register clears when consumed.
REQ-027 A selected target with [1:0] != 2'b00 sets addr_err, leaves pc unchanged and enters S_ERR.
REQ-028 With IMEM_TIMEOUT nonzero, a request outstanding for IMEM_TIMEOUT cycles without imem_ack sets addr_err and enters S_ERR.
REQ-029 imem_addr stays stable while imem_req=1 and imem_ack=0.
REQ-030 pc=32'hFFFF_FFFC advancing sequentially wraps to 32'h0000_0000, with no error.
REQ-031 Stall asserted in the same cycle as imem_ack still pulses instr_valid; only the PC update is deferred.

Reset
REQ-032 While rst_n=0 the block SHALL hold:
- pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4
- imem_req=0, instr_valid=0, addr_err=0
- pending register empty, timeout counter 0, state S_BOOT
REQ-033 Reset asserted mid-request drops imem_req asynchronously, and the block discards any later imem_ack until S_FETCH is re-entered.

Structure
REQ-034 Package mips_pc_pkg holds the FSM state enum, the redirect-type enum (SEQ/BR/J/JR) and the PC_INC=32'd4 constant.
REQ-035 Sub-module next_pc_sel holds the combinational target and priority selection plus the alignment check; pc_fetch_unit holds the FSM, PC register, pending register and timeout counter.

Verification
REQ-036 Reset release, imem_ack held high, no redirects -> imem_addr sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, with instr_valid high each cycle.
REQ-037 pc=0x100 with branch_taken=1 and branch_addr=32'hFFFF_FFFE at ack -> next pc=0xFC; with branch_addr=0x10 -> next pc=0x144.
REQ-038 pc=0x9000_0010 with jump=1, jump_addr=28'h000_0040 and branch_taken=1 at ack -> next pc=0x9000_0040 (jump wins).
REQ-039 jump_reg=1 with jr_addr=0x2000 while stall=1, then stall released -> pc=0x2000 on the first advance; jr_addr=0x2002 -> addr_err=1, imem_req=0, pc held.
REQ-040 pc=0xFFFF_FFFC, sequential advance -> pc=0x0000_0000 and addr_err stays 0.
REQ-041 IMEM_TIMEOUT=4 with imem_ack held low -> addr_err=1 after 4 request cycles; rst_n pulsed low -> pc=RESET_VECTOR and addr_err=0.
